// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must index bits 0..w-1; never let it collapse to zero width.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder: the only arithmetic hardware the serial adder uses.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ab_x;

  assign ab_x = a ^ b;
  assign s    = ab_x ^ ci;
  assign co   = (a & b) | (ab_x & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell walked LSB-first across WIDTH bits.
// Optional subtract mode (extra "sub" port) is enabled with `define SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, f_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg, cout_reg, overflow_reg, busy_reg, done_reg;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             cell_s, cell_c;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as A + ~B + 1: invert B and force the initial carry.
  assign b_load     = sub ? ~B : B;
  assign carry_load = sub ? 1'b1 : Cin;
`else
  assign b_load     = B;
  assign carry_load = Cin;
`endif

  fa_cell u_cell (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .ci (carry_reg),
    .s  (cell_s),
    .co (cell_c)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      f_reg        <= '0;
      cnt_reg      <= '0;
      carry_reg    <= 1'b0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg     <= A;
            b_sh_reg     <= b_load;
            carry_reg    <= carry_load;
            cnt_reg      <= '0;
            f_reg        <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
          end
        end
        RUN: begin
          f_reg     <= {cell_s, f_reg[WIDTH-1:1]};
          a_sh_reg  <= a_sh_reg >> 1;
          b_sh_reg  <= b_sh_reg >> 1;
          carry_reg <= cell_c;
          cnt_reg   <= cnt_reg + 1'b1;
          // On the MSB, carry_reg is the carry into bit WIDTH-1.
          if (cnt_reg == LAST_BIT) begin
            cout_reg     <= cell_c;
            overflow_reg <= carry_reg ^ cell_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign F        = f_reg;
  assign Cout     = cout_reg;
  assign overflow = overflow_reg;

endmodule
